power_stage_ctrl: RTL and testbench

POWER_STAGE_CTRL -- requirements
Module: power_stage_ctrl

---
 rtl/power_pkg.sv | 21 ++
 rtl/power_stage_ctrl_if.sv | 12 +
 rtl/overcurrent_filter.sv | 48 ++++
 rtl/power_stage_ctrl.sv | 131 +++++++++++++
 tb/tb_power_stage_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/power_pkg.sv
// Shared types and constants for the power stage controller.
package power_pkg;

  // ADC current code width.
  localparam int ADC_W = 12;

  // Controller states; the encoding is also what state_o reports.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SOFT_START = 3'd1,
    ST_RUN        = 3'd2,
    ST_COOLDOWN   = 3'd3,
    ST_LOCKOUT    = 3'd4
  } state_e;

  // Larger of two integers, used to size the shared phase timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/power_stage_ctrl_if.sv
// ADC sample stream into the power stage controller.
// Handshake: sample_valid qualifies current_sample in the cycle it is high.
// There is no ready/backpressure; the controller consumes every valid sample.
interface power_stage_ctrl_if;
  import power_pkg::*;

  logic [ADC_W-1:0] current_sample;
  logic             sample_valid;

  modport master (output current_sample, output sample_valid);
  modport slave  (input  current_sample, input  sample_valid);
endinterface

// File: rtl/overcurrent_filter.sv
// Consecutive over-limit sample filter. trip is combinational so the
// controller can leave RUN on the same edge that samples the tripping sample.
module overcurrent_filter
  import power_pkg::*;
#(
  parameter logic [ADC_W-1:0] CURRENT_LIMIT = 12'd2500,
  parameter int               TRIP_SAMPLES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,        // controller is currently in RUN
  input  logic             flush,         // controller will not be in RUN next cycle
  input  logic [ADC_W-1:0] sample,
  input  logic             sample_valid,
  output logic             trip
);

  localparam int            CW        = $clog2(TRIP_SAMPLES + 1);
  localparam logic [CW-1:0] TRIP_MAX  = CW'(TRIP_SAMPLES);
  localparam logic [CW-1:0] TRIP_LAST = CW'(TRIP_SAMPLES - 1);

  logic          over;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A sample equal to the limit is not over-limit.
  assign over = sample_valid && (sample > CURRENT_LIMIT);
  assign trip = active && over && (cnt_q >= TRIP_LAST);

  // Counter update: count over-limit, clear on valid in-limit, hold on no sample.
  always_comb begin
    cnt_d = cnt_q;
    if (!active || flush) begin
      cnt_d = '0;
    end else if (over) begin
      cnt_d = (cnt_q == TRIP_MAX) ? cnt_q : cnt_q + CW'(1);
    end else if (sample_valid) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/power_stage_ctrl.sv
// Power stage controller: soft start, overcurrent trip with timed retry,
// and lockout after too many retries. All outputs are registered.
module power_stage_ctrl
  import power_pkg::*;
#(
  parameter logic [ADC_W-1:0] CURRENT_LIMIT     = 12'd2500,
  parameter int               TRIP_SAMPLES      = 4,
  parameter int               SOFT_START_CYCLES = 1000,
  parameter int               COOLDOWN_CYCLES   = 50000,
  parameter int               MAX_RETRIES       = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable_req,
  power_stage_ctrl_if.slave                  adc,
  input  logic                               fault_clear,
  output logic                               stage_en,
  output logic                               fault,
  output logic                               lockout,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [2:0]                         state_o
);

  localparam int             RCW       = $clog2(MAX_RETRIES + 1);
  localparam int             TW        = $clog2(max_int(SOFT_START_CYCLES, COOLDOWN_CYCLES) + 1);
  localparam logic [TW-1:0]  SS_LAST   = TW'(SOFT_START_CYCLES - 1);
  localparam logic [TW-1:0]  CD_LAST   = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRIES);

  state_e         state_q;
  state_e         state_d;
  logic [TW-1:0]  timer_q;
  logic [TW-1:0]  timer_d;
  logic [RCW-1:0] retry_q;
  logic [RCW-1:0] retry_d;
  logic           trip;
  logic           stage_en_q;
  logic           fault_q;
  logic           lockout_q;

  overcurrent_filter #(
    .CURRENT_LIMIT (CURRENT_LIMIT),
    .TRIP_SAMPLES  (TRIP_SAMPLES)
  ) u_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .active       (state_q == ST_RUN),
    .flush        (state_d != ST_RUN),
    .sample       (adc.current_sample),
    .sample_valid (adc.sample_valid),
    .trip         (trip)
  );

  // Next-state logic; a trip in RUN takes priority over enable_req dropping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_req) state_d = ST_SOFT_START;
      end
      ST_SOFT_START: begin
        if (!enable_req)            state_d = ST_IDLE;
        else if (timer_q == SS_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trip)             state_d = (retry_q < RETRY_MAX) ? ST_COOLDOWN : ST_LOCKOUT;
        else if (!enable_req) state_d = ST_IDLE;
      end
      ST_COOLDOWN: begin
        if (timer_q == CD_LAST) state_d = enable_req ? ST_SOFT_START : ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (fault_clear && !enable_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase timer runs only in timed states and restarts on every state change.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == ST_SOFT_START || state_q == ST_COOLDOWN) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Retry counter: cleared on IDLE, bumped on each COOLDOWN entry.
  always_comb begin
    retry_d = retry_q;
    if (state_d == ST_IDLE) begin
      retry_d = '0;
    end else if (state_d == ST_COOLDOWN && state_q != ST_COOLDOWN) begin
      retry_d = retry_q + RCW'(1);
    end
  end

  // State, timer and retry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // Registered outputs decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_en_q <= 1'b0;
      fault_q    <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      stage_en_q <= (state_d == ST_SOFT_START) || (state_d == ST_RUN);
      fault_q    <= (state_d == ST_COOLDOWN) || (state_d == ST_LOCKOUT);
      lockout_q  <= (state_d == ST_LOCKOUT);
    end
  end

  assign stage_en    = stage_en_q;
  assign fault       = fault_q;
  assign lockout     = lockout_q;
  assign retry_count = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_power_stage_ctrl.sv
// Bench for power_stage_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the controller rules.
module tb_power_stage_ctrl;
  import power_pkg::*;

  localparam logic [11:0] LIMIT  = 12'd2500;
  localparam int          TRIP_N = 4;
  localparam int          SS_N   = 10;
  localparam int          CD_N   = 20;
  localparam int          MAX_R  = 2;
  localparam int          RCW    = 2;
  localparam int          EW     = 6 + RCW;

  localparam int M_IDLE = 0, M_SS = 1, M_RUN = 2, M_CD = 3, M_LOCK = 4;

  // Clock and reset
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable_req = 1'b0;
  logic           fault_clear = 1'b0;
  logic           stage_en;
  logic           fault;
  logic           lockout;
  logic [RCW-1:0] retry_count;
  logic [2:0]     state_o;

  power_stage_ctrl_if adc_if ();

  power_stage_ctrl #(
    .CURRENT_LIMIT     (LIMIT),
    .TRIP_SAMPLES      (TRIP_N),
    .SOFT_START_CYCLES (SS_N),
    .COOLDOWN_CYCLES   (CD_N),
    .MAX_RETRIES       (MAX_R)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_req  (enable_req),
    .adc         (adc_if.slave),
    .fault_clear (fault_clear),
    .stage_en    (stage_en),
    .fault       (fault),
    .lockout     (lockout),
    .retry_count (retry_count),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  // Behavioural model: phase, cycles spent in phase, consecutive overs, trips
  int m_mode, m_timer, m_cnt, m_retries;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] mode_state(input int md);
    case (md)
      M_SS:    return ST_SOFT_START;
      M_RUN:   return ST_RUN;
      M_CD:    return ST_COOLDOWN;
      M_LOCK:  return ST_LOCKOUT;
      default: return ST_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_timer = 0; m_cnt = 0; m_retries = 0;
  endtask

  task automatic model_idle();
    m_mode = M_IDLE; m_timer = 0; m_cnt = 0; m_retries = 0;
  endtask

  task automatic model_step(input bit en, input logic [11:0] smp, input bit vld, input bit fc);
    bit over;
    over = vld && (smp > LIMIT);
    case (m_mode)
      M_IDLE: if (en) begin m_mode = M_SS; m_timer = 0; end
      M_SS: begin
        if (!en) model_idle();
        else begin
          m_timer++;
          if (m_timer == SS_N) begin m_mode = M_RUN; m_cnt = 0; end
        end
      end
      M_RUN: begin
        if (over) m_cnt++;
        else if (vld) m_cnt = 0;
        if (m_cnt >= TRIP_N) begin
          m_cnt = 0;
          if (m_retries < MAX_R) begin m_mode = M_CD; m_timer = 0; m_retries++; end
          else m_mode = M_LOCK;
        end else if (!en) model_idle();
      end
      M_CD: begin
        m_timer++;
        if (m_timer == CD_N) begin
          if (en) begin m_mode = M_SS; m_timer = 0; end
          else model_idle();
        end
      end
      M_LOCK: if (fc && !en) model_idle();
      default: model_idle();
    endcase
  endtask

  function automatic logic [EW-1:0] model_vec();
    logic se, fl, lk;
    se = (m_mode == M_SS) || (m_mode == M_RUN);
    fl = (m_mode == M_CD) || (m_mode == M_LOCK);
    lk = (m_mode == M_LOCK);
    return {mode_state(m_mode), se, fl, lk, RCW'(m_retries)};
  endfunction

  task automatic compare_out();
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check_val("state_o",     state_o,     e[EW-1:EW-3]);
    check_val("stage_en",    stage_en,    e[RCW+2]);
    check_val("fault",       fault,       e[RCW+1]);
    check_val("lockout",     lockout,     e[RCW]);
    check_val("retry_count", retry_count, e[RCW-1:0]);
  endtask

  // Driver: apply inputs, clock once, predict, then sample 1 ns after the edge.
  task automatic step(input bit en, input logic [11:0] smp, input bit vld, input bit fc);
    enable_req = en;
    adc_if.current_sample = smp;
    adc_if.sample_valid   = vld;
    fault_clear           = fc;
    @(posedge clk);
    model_step(en, smp, vld, fc);
    exp_q.push_back(model_vec());
    #1;
    compare_out();
  endtask

  task automatic run_n(input int n, input bit en, input logic [11:0] smp);
    for (int i = 0; i < n; i++) step(en, smp, 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear without a clock edge.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_val({tag, "_stage_en"},    stage_en,    0);
    check_val({tag, "_fault"},       fault,       0);
    check_val({tag, "_lockout"},     lockout,     0);
    check_val({tag, "_retry_count"}, retry_count, 0);
    check_val({tag, "_state"},       state_o,     ST_IDLE);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [11:0] rand_sample();
    case ($urandom_range(0, 5))
      0:       return 12'd2499;
      1:       return 12'd2500;
      2:       return 12'd2501;
      3:       return 12'd2600;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    adc_if.current_sample = '0;
    adc_if.sample_valid   = 1'b0;
    model_reset();
    #12;
    pulse_reset("reset");

    // Soft start then RUN with nominal current
    run_n(SS_N + 2, 1'b1, 12'd1000);
    check_val("start_run_stage_en", stage_en, 1);
    check_val("start_run_state", state_o, ST_RUN);

    // Equal-to-limit sample breaks the run of overs
    run_n(3, 1'b1, 12'd2600);
    run_n(1, 1'b1, 12'd2500);
    run_n(3, 1'b1, 12'd2600);
    check_val("no_trip_fault", fault, 0);
    run_n(1, 1'b1, 12'd2600);
    check_val("trip1_stage_en", stage_en, 0);
    check_val("trip1_fault", fault, 1);
    check_val("trip1_retry", retry_count, 1);

    // Cooldown, then blanked overcurrent during soft start
    run_n(CD_N, 1'b1, 12'd1000);
    check_val("cd1_exit_state", state_o, ST_SOFT_START);
    run_n(SS_N, 1'b1, 12'd4000);
    check_val("blank_state", state_o, ST_RUN);
    check_val("blank_fault", fault, 0);

    // Second trip, retry, third trip into lockout
    run_n(TRIP_N, 1'b1, 12'd2600);
    check_val("trip2_retry", retry_count, 2);
    run_n(CD_N + SS_N, 1'b1, 12'd1000);
    run_n(TRIP_N, 1'b1, 12'd2600);
    check_val("trip3_lockout", lockout, 1);
    check_val("trip3_retry", retry_count, 2);
    for (int i = 0; i < 3; i++) step(1'b1, 12'd1000, 1'b1, 1'b1);
    check_val("clear_ignored_lockout", lockout, 1);
    step(1'b0, 12'd1000, 1'b1, 1'b1);
    check_val("clear_state", state_o, ST_IDLE);
    check_val("clear_retry", retry_count, 0);

    // Trip coinciding with enable_req falling
    run_n(SS_N + 1, 1'b1, 12'd1000);
    run_n(TRIP_N - 1, 1'b1, 12'd2600);
    step(1'b0, 12'd2600, 1'b1, 1'b0);
    check_val("trip_vs_disable_fault", fault, 1);
    run_n(CD_N, 1'b0, 12'd1000);
    check_val("trip_vs_disable_idle", state_o, ST_IDLE);

    // Asynchronous reset in RUN and in LOCKOUT
    run_n(SS_N + 2, 1'b1, 12'd1000);
    pulse_reset("rst_run");
    run_n(SS_N + 1, 1'b1, 12'd1000);
    for (int i = 0; i <= MAX_R; i++) begin
      run_n(TRIP_N, 1'b1, 12'd2600);
      if (i < MAX_R) run_n(CD_N + SS_N, 1'b1, 12'd1000);
    end
    check_val("pre_rst_lockout", lockout, 1);
    pulse_reset("rst_lock");

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset("rst_rand");
      step(($urandom_range(0, 9) != 0), rand_sample(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
